adder_stream_driver: RTL and testbench
======================================

# adder_stream_driver

Initiator-side companion to `adder`. It accepts operand pairs over a valid/ready stream and drives `adder`'s `a`, `b` and `valid` inputs. It captures each `c` result a fixed latency later and returns the results in order on a valid/ready result stream. A local reference sum is checked against every `c` to flag mismatches. It sits between a test or command source and one `adder` instance; credit-based flow control keeps the result FIFO from overflowing.

## Interface
- `RESULT_LATENCY`, default 1: cycles from `valid` high to `c` valid at the adder output; legal range 1..8.
- `FIFO_DEPTH`, default 4: result FIFO entries, which is also the maximum number of outstanding operations; power of two, 2..16.
- `clk`  in  1  sole clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0).
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  operand pair accepted when `in_valid && in_ready`.
- `in_a`  in  4  operand A.
- `in_b`  in  4  operand B.
- `a`  out  4  to adder `a`, registered.
- `b`  out  4  to adder `b`, registered.
- `valid`  out  1  to adder `valid`, registered, one cycle per operation.
- `c`  in  7  from adder `c`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed when `res_valid && res_ready`.
- `res_data`  out  7  captured `c`.
- `res_mismatch`  out  1  `res_data` differs from the reference sum; qualified by `res_valid`.
- `err_count`  out  8  saturating count of mismatched results captured.

## Operation
- **Credit counter**
  - Width is clog2(FIFO_DEPTH)+1; reset value FIFO_DEPTH.
  - Issue decrements it, pop increments it; simultaneous issue and pop leave it unchanged.
  - `in_ready` = (credits != 0) && reset deasserted. It never depends on `res_ready` combinationally.
- **Issue**
  - On accept, register `a<=in_a`, `b<=in_b`, `valid<=1` for the next cycle.
  - With no accept, `valid<=0`; `a`/`b` hold their last values.
  - Back-to-back accepts give `valid` high on consecutive cycles.
- **Tracking pipeline**
  - A RESULT_LATENCY-stage shift register carries a tag bit plus the 5-bit reference sum `in_a+in_b`, zero-extended to 7 bits, for each issued operation.
  - The stage aligned with `c` marks the capture cycle.
- **Capture**
  - When the aligned tag is 1, push {`c`, mismatch = (`c` != ref)} into the FIFO.
  - The push cannot be refused: credits guarantee space.
  - On a mismatch push, `err_count` increments and saturates at 255.
- **Result FIFO**
  - Registered read pointer, write pointer and count.
  - `res_valid` = count != 0. `res_data` and `res_mismatch` show the head entry.
  - Push and pop in the same cycle at any occupancy, including full or empty-with-push, are legal.
  - A pop when empty does not occur, since `res_valid` = 0.
- **State**: the block has no FSM beyond the counters. Pointers wrap modulo FIFO_DEPTH.

## Timing
- **Reset** (while `reset`=0 at a clock edge):
  - `a`=0, `b`=0, `valid`=0, `res_valid`=0, `res_data`=0, `res_mismatch`=0, `err_count`=0, `in_ready`=0.
  - Credits = FIFO_DEPTH, pipeline tags cleared, FIFO emptied.
- **Reset mid-operation**: in-flight operations and buffered results are dropped. `c` arriving after reset for pre-reset operations is ignored because its tags are cleared.
- **First accept**: possible in the first cycle after `reset` returns to 1.
- **Latency**
  - Accept at edge N gives `valid`=1 during cycle N+1.
  - `c` is sampled at edge N+1+RESULT_LATENCY.
  - `res_valid`=1 from cycle N+2+RESULT_LATENCY when the FIFO was empty.
  - Minimum accept-to-result latency is 2+RESULT_LATENCY cycles.
- **Throughput**: one operation per cycle sustained when `res_ready`=1 continuously and FIFO_DEPTH ≥ RESULT_LATENCY+2.
- **Pop timing**: credits freed by a pop at edge M make `in_ready` high in cycle M+1.
- **Ordering**: results are returned strictly in issue order.

## Test plan
- **Single op**: reset low 2 cycles, then accept a=3, b=4 with latency-1 adder model → `valid` high exactly 1 cycle; `res_valid` 3 cycles after accept; `res_data`=7, `res_mismatch`=0, `err_count`=0.
- **Backpressure/full**: `res_ready`=0, offer 6 ops (1+1 … 6+6) with FIFO_DEPTH=4 → exactly 4 accepted, then `in_ready`=0. Raise `res_ready` → results 2, 4, 6, 8 in order, then the remaining 2 accepted and returned as 10, 12.
- **Streaming**: `res_ready`=1, 32 back-to-back random ops, RESULT_LATENCY=1 and 3 → `in_ready` never drops; all 32 sums correct and in order.
- **Mismatch**: adder model corrupts the 3rd result (15+15 returns 29) → that result `res_mismatch`=1, others 0; `err_count`=1. Forcing 300 mismatches leaves `err_count`=255.
- **Simultaneous push/pop at full**: FIFO full, `res_ready`=1 while a capture lands → count stays at FIFO_DEPTH, no data loss, credits unchanged.
- **Reset mid-flight**: 3 ops outstanding, 2 buffered; assert `reset` for 1 cycle → `res_valid`=0, `in_ready`=1 the cycle after release, late `c` ignored, credits = FIFO_DEPTH (4 ops accepted next).

Source files
------------

// File: rtl/adder_stream_driver.sv
// rtl/adder_stream_driver.sv - operand stream to adder driver with in-order result capture and checking
module adder_stream_driver #(
    parameter int RESULT_LATENCY = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       valid,
    input  logic [6:0] c,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [6:0] res_data,
    output logic       res_mismatch,
    output logic [7:0] err_count
);

    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;
    localparam int PIPE_W = RESULT_LATENCY * 7;

    logic                               accept;
    logic                               pop;
    logic                               push;
    logic                               cap_mismatch;
    logic [4:0]                         sum5;
    logic [6:0]                         ref_sum;
    logic [6:0]                         aligned_ref;
    logic [7:0]                         head;

    logic [3:0]                         a_q;
    logic [3:0]                         b_q;
    logic                               valid_q;
    logic [6:0]                         ref_q;

    logic [RESULT_LATENCY-1:0]          tag_q;
    logic [RESULT_LATENCY-1:0][6:0]     ref_pipe_q;

    logic [CW-1:0]                      credits_q;
    logic [CW-1:0]                      credits_d;
    logic [CW-1:0]                      count_q;
    logic [CW-1:0]                      count_d;
    logic [PW-1:0]                      wr_ptr_q;
    logic [PW-1:0]                      wr_ptr_d;
    logic [PW-1:0]                      rd_ptr_q;
    logic [PW-1:0]                      rd_ptr_d;
    logic [7:0]                         err_q;
    logic [7:0]                         err_d;

    // Each entry holds {mismatch, captured c}.
    logic [7:0]                         mem_q [FIFO_DEPTH];

    // Credits count free FIFO slots not yet claimed by an in-flight operation,
    // so any operation that gets issued is guaranteed a slot when its result lands.
    assign in_ready = (credits_q != '0) && reset;
    assign accept   = in_valid && in_ready;
    assign pop      = res_valid && res_ready;

    assign sum5     = {1'b0, in_a} + {1'b0, in_b};
    assign ref_sum  = {2'b00, sum5};

    // The oldest pipeline stage lines up with the cycle in which c carries that operation's sum.
    assign push         = tag_q[RESULT_LATENCY-1];
    assign aligned_ref  = ref_pipe_q[RESULT_LATENCY-1];
    assign cap_mismatch = (c != aligned_ref);

    assign head         = mem_q[rd_ptr_q];
    assign res_valid    = (count_q != '0);
    assign res_data     = res_valid ? head[6:0] : 7'd0;
    assign res_mismatch = res_valid ? head[7] : 1'b0;

    assign a         = a_q;
    assign b         = b_q;
    assign valid     = valid_q;
    assign err_count = err_q;

    // Next-state for credits, FIFO occupancy/pointers and the saturating error counter.
    always_comb begin
        credits_d = credits_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        err_d     = err_q;

        if (accept && !pop) begin
            credits_d = credits_q - CW'(1);
        end else if (!accept && pop) begin
            credits_d = credits_q + CW'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (push && cap_mismatch && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    // Issue stage: drive the adder for exactly one cycle per accepted operand pair.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            valid_q <= 1'b0;
            ref_q   <= 7'd0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                a_q   <= in_a;
                b_q   <= in_b;
                ref_q <= ref_sum;
            end
        end
    end

    // Tracking pipeline: tag and reference sum follow each issued operation toward its c.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_q      <= '0;
            ref_pipe_q <= '0;
        end else begin
            tag_q      <= RESULT_LATENCY'({tag_q, valid_q});
            ref_pipe_q <= PIPE_W'({ref_pipe_q, ref_q});
        end
    end

    // Counters and pointers; a reset drops everything in flight or buffered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            credits_q <= CW'(FIFO_DEPTH);
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_q     <= 8'd0;
        end else begin
            credits_q <= credits_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_q     <= err_d;
        end
    end

    // Result storage; contents need no reset because outputs are masked by res_valid.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= {cap_mismatch, c};
        end
    end

endmodule

// File: tb/tb_adder_stream_driver.sv
// tb/tb_adder_stream_driver.sv - directed self-checking bench for adder_stream_driver
module tb_adder_stream_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       res_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;

    logic       in_ready1, valid1, res_valid1, res_mismatch1;
    logic [3:0] a1, b1;
    logic [6:0] c1, res_data1;
    logic [7:0] err_count1;

    logic       in_ready3, valid3, res_valid3, res_mismatch3;
    logic [3:0] a3, b3;
    logic [6:0] c3, res_data3;
    logic [7:0] err_count3;

    logic       corrupt_en  = 1'b0;
    logic       corrupt_all = 1'b0;

    int checks = 0;
    int errors = 0;

    int         acc1, acc3, vcnt1, vcnt3;
    logic [6:0] got1_d [$];
    logic       got1_m [$];
    logic [6:0] got3_d [$];
    logic       got3_m [$];

    always #5 clk = ~clk;

    adder_stream_driver #(.RESULT_LATENCY(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .a(a1), .b(b1), .valid(valid1), .c(c1),
        .res_valid(res_valid1), .res_ready(res_ready), .res_data(res_data1),
        .res_mismatch(res_mismatch1), .err_count(err_count1)
    );

    adder_stream_driver #(.RESULT_LATENCY(3), .FIFO_DEPTH(8)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
        .in_a(in_a), .in_b(in_b), .a(a3), .b(b3), .valid(valid3), .c(c3),
        .res_valid(res_valid3), .res_ready(res_ready), .res_data(res_data3),
        .res_mismatch(res_mismatch3), .err_count(err_count3)
    );

    // Adder models: latency 1 with optional corruption, latency 3 clean.
    logic [6:0] s1, s3, p1, p3a, p3b, p3c;
    assign s1 = {3'b000, a1} + {3'b000, b1};
    assign s3 = {3'b000, a3} + {3'b000, b3};
    assign c1 = p1;
    assign c3 = p3c;

    always @(posedge clk) begin
        if (corrupt_all)
            p1 <= s1 + 7'd1;
        else if (corrupt_en && a1 == 4'd15 && b1 == 4'd15)
            p1 <= 7'd29;
        else
            p1 <= s1;
        p3a <= s3;
        p3b <= p3a;
        p3c <= p3b;
    end

    // Handshake monitor: inputs are stable from negedge to the next posedge.
    always @(negedge clk) begin
        if (!reset) begin
            acc1 = 0; acc3 = 0; vcnt1 = 0; vcnt3 = 0;
            got1_d.delete(); got1_m.delete(); got3_d.delete(); got3_m.delete();
        end else begin
            if (in_valid && in_ready1) acc1++;
            if (in_valid && in_ready3) acc3++;
            if (valid1) vcnt1++;
            if (valid3) vcnt3++;
            if (res_valid1 && res_ready) begin got1_d.push_back(res_data1); got1_m.push_back(res_mismatch1); end
            if (res_valid3 && res_ready) begin got3_d.push_back(res_data3); got3_m.push_back(res_mismatch3); end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic send1(input logic [3:0] x, input logic [3:0] y);
        in_a = x; in_b = y; in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready1) break;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; res_ready = 1'b0; in_a = 4'd0; in_b = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (a1 !== 4'd0) begin errors++; $display("FAIL reset_a: got %0d expected 0", a1); end
        checks++; if (b1 !== 4'd0) begin errors++; $display("FAIL reset_b: got %0d expected 0", b1); end
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid1); end
        checks++; if (res_valid1 !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b expected 0", res_valid1); end
        checks++; if (res_data1 !== 7'd0) begin errors++; $display("FAIL reset_res_data: got %0d expected 0", res_data1); end
        checks++; if (res_mismatch1 !== 1'b0) begin errors++; $display("FAIL reset_res_mismatch: got %0b expected 0", res_mismatch1); end
        checks++; if (err_count1 !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count1); end
        checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready1); end
        checks++; if (in_ready3 !== 1'b0) begin errors++; $display("FAIL reset_in_ready_l3: got %0b expected 0", in_ready3); end
        @(posedge clk); #1 reset = 1'b1;
    endtask

    task automatic test_single_op();
        res_ready = 1'b0;
        in_a = 4'd3; in_b = 4'd4; in_valid = 1'b1;
        @(negedge clk);
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL single_first_ready: got %0b expected 1", in_ready1); end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL single_valid_hi: got %0b expected 1", valid1); end
        checks++; if (a1 !== 4'd3 || b1 !== 4'd4) begin errors++; $display("FAIL single_ab: got a=%0d b=%0d expected a=3 b=4", a1, b1); end
        checks++; if (res_valid1 !== 1'b0) begin errors++; $display("FAIL single_early1: got res_valid=%0b expected 0", res_valid1); end
        @(negedge clk);
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL single_valid_lo: got %0b expected 0", valid1); end
        checks++; if (res_valid1 !== 1'b0) begin errors++; $display("FAIL single_early2: got res_valid=%0b expected 0", res_valid1); end
        @(negedge clk);
        checks++; if (res_valid1 !== 1'b1) begin errors++; $display("FAIL single_res_valid: got %0b expected 1", res_valid1); end
        checks++; if (res_data1 !== 7'd7) begin errors++; $display("FAIL single_res_data: got %0d expected 7", res_data1); end
        checks++; if (res_mismatch1 !== 1'b0) begin errors++; $display("FAIL single_mismatch: got %0b expected 0", res_mismatch1); end
        checks++; if (err_count1 !== 8'd0) begin errors++; $display("FAIL single_err_count: got %0d expected 0", err_count1); end
        checks++; if (vcnt1 !== 1) begin errors++; $display("FAIL single_valid_cycles: got %0d expected 1", vcnt1); end
        @(posedge clk); #1 res_ready = 1'b1;
        @(posedge clk); #1 res_ready = 1'b0;
        @(negedge clk);
        checks++; if (res_valid1 !== 1'b0) begin errors++; $display("FAIL single_popped: got res_valid=%0b expected 0", res_valid1); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic blocked;
        do_reset();
        for (int i = 1; i <= 4; i++) send1(4'(i), 4'(i));
        in_a = 4'd5; in_b = 4'd5; in_valid = 1'b1;
        blocked = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (in_ready1) blocked = 1'b0;
        end
        checks++; if (blocked !== 1'b1) begin errors++; $display("FAIL bp_blocked: in_ready rose while full, expected stay 0"); end
        checks++; if (acc1 !== 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", acc1); end
        checks++; if (res_valid1 !== 1'b1 || res_data1 !== 7'd2) begin errors++; $display("FAIL bp_head: got valid=%0b data=%0d expected 1/2", res_valid1, res_data1); end
        @(posedge clk); #1 res_ready = 1'b1;
        send1(4'd5, 4'd5);
        send1(4'd6, 4'd6);
        for (int k = 0; k < 60 && got1_d.size() < 6; k++) @(negedge clk);
        checks++; if (got1_d.size() != 6) begin errors++; $display("FAIL bp_count: got %0d results expected 6", got1_d.size()); end
        checks++; if (acc1 !== 6) begin errors++; $display("FAIL bp_accepted_total: got %0d expected 6", acc1); end
        for (int i = 0; i < got1_d.size(); i++) begin
            checks++;
            if (got1_d[i] !== 7'(2 * (i + 1)) || got1_m[i] !== 1'b0)
                begin errors++; $display("FAIL bp_result[%0d]: got %0d/%0b expected %0d/0", i, got1_d[i], got1_m[i], 2 * (i + 1)); end
        end
        @(posedge clk); #1 res_ready = 1'b0;
    endtask

    task automatic test_full_pushpop();
        logic [6:0] exp_d [8];
        exp_d = '{7'd10, 7'd5, 7'd8, 7'd15, 7'd15, 7'd2, 7'd0, 7'd29};
        do_reset();
        send1(4'd9, 4'd1); send1(4'd2, 4'd3); send1(4'd4, 4'd4); send1(4'd8, 4'd7);
        repeat (3) @(negedge clk);
        checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %0b expected 0", in_ready1); end
        checks++; if (res_data1 !== 7'd10) begin errors++; $display("FAIL full_head: got %0d expected 10", res_data1); end
        @(posedge clk); #1;
        res_ready = 1'b1; in_a = 4'd6; in_b = 4'd9; in_valid = 1'b1;
        @(negedge clk);
        checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL full_ready_before_pop: got %0b expected 0", in_ready1); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %0b expected 1", in_ready1); end
        @(posedge clk); #1 in_valid = 1'b0;
        send1(4'd1, 4'd1); send1(4'd0, 4'd0); send1(4'd15, 4'd14);
        for (int k = 0; k < 60 && got1_d.size() < 8; k++) @(negedge clk);
        checks++; if (got1_d.size() != 8) begin errors++; $display("FAIL full_count: got %0d results expected 8", got1_d.size()); end
        for (int i = 0; i < got1_d.size() && i < 8; i++) begin
            checks++;
            if (got1_d[i] !== exp_d[i]) begin errors++; $display("FAIL full_result[%0d]: got %0d expected %0d", i, got1_d[i], exp_d[i]); end
        end
        @(negedge clk);
        checks++; if (res_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin errors++; $display("FAIL full_drained: got res_valid=%0b in_ready=%0b expected 0/1", res_valid1, in_ready1); end
        @(posedge clk); #1 res_ready = 1'b0;
    endtask

    task automatic test_streaming();
        logic [6:0] exp_d [32];
        logic       dropped;
        do_reset();
        res_ready = 1'b1;
        dropped = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_a = 4'($urandom_range(0, 15));
            in_b = 4'($urandom_range(0, 15));
            exp_d[i] = {3'b000, in_a} + {3'b000, in_b};
            @(negedge clk);
            if (!(in_ready1 && in_ready3)) dropped = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 60 && (got1_d.size() < 32 || got3_d.size() < 32); k++) @(negedge clk);
        checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL stream_ready_drop: in_ready fell, expected stay 1"); end
        checks++; if (acc1 !== 32 || acc3 !== 32) begin errors++; $display("FAIL stream_accepts: got %0d/%0d expected 32/32", acc1, acc3); end
        checks++; if (vcnt1 !== 32 || vcnt3 !== 32) begin errors++; $display("FAIL stream_valid_cycles: got %0d/%0d expected 32/32", vcnt1, vcnt3); end
        checks++; if (got1_d.size() != 32 || got3_d.size() != 32) begin errors++; $display("FAIL stream_count: got %0d/%0d expected 32/32", got1_d.size(), got3_d.size()); end
        for (int i = 0; i < got1_d.size() && i < 32; i++) begin
            checks++;
            if (got1_d[i] !== exp_d[i] || got1_m[i] !== 1'b0) begin errors++; $display("FAIL stream_l1[%0d]: got %0d/%0b expected %0d/0", i, got1_d[i], got1_m[i], exp_d[i]); end
        end
        for (int i = 0; i < got3_d.size() && i < 32; i++) begin
            checks++;
            if (got3_d[i] !== exp_d[i] || got3_m[i] !== 1'b0) begin errors++; $display("FAIL stream_l3[%0d]: got %0d/%0b expected %0d/0", i, got3_d[i], got3_m[i], exp_d[i]); end
        end
        checks++; if (err_count3 !== 8'd0) begin errors++; $display("FAIL stream_err_l3: got %0d expected 0", err_count3); end
        @(posedge clk); #1 res_ready = 1'b0;
    endtask

    task automatic test_mismatch();
        logic [6:0] exp_d [4];
        logic       exp_m [4];
        int         ones;
        exp_d = '{7'd3, 7'd11, 7'd29, 7'd7};
        exp_m = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        res_ready = 1'b1; corrupt_en = 1'b1;
        send1(4'd1, 4'd2); send1(4'd5, 4'd6); send1(4'd15, 4'd15); send1(4'd7, 4'd0);
        for (int k = 0; k < 40 && got1_d.size() < 4; k++) @(negedge clk);
        checks++; if (got1_d.size() != 4) begin errors++; $display("FAIL mm_count: got %0d expected 4", got1_d.size()); end
        for (int i = 0; i < got1_d.size() && i < 4; i++) begin
            checks++;
            if (got1_d[i] !== exp_d[i] || got1_m[i] !== exp_m[i]) begin errors++; $display("FAIL mm_result[%0d]: got %0d/%0b expected %0d/%0b", i, got1_d[i], got1_m[i], exp_d[i], exp_m[i]); end
        end
        checks++; if (err_count1 !== 8'd1) begin errors++; $display("FAIL mm_err_count: got %0d expected 1", err_count1); end
        @(posedge clk); #1;
        corrupt_en = 1'b0; corrupt_all = 1'b1;
        for (int i = 0; i < 300; i++) send1(4'(i), 4'(i + 3));
        for (int k = 0; k < 60 && got1_d.size() < 304; k++) @(negedge clk);
        @(posedge clk); #1 corrupt_all = 1'b0;
        ones = 0;
        foreach (got1_m[i]) if (got1_m[i] === 1'b1) ones++;
        checks++; if (ones !== 301) begin errors++; $display("FAIL mm_flag_total: got %0d expected 301", ones); end
        checks++; if (err_count1 !== 8'd255) begin errors++; $display("FAIL mm_saturate: got %0d expected 255", err_count1); end
        res_ready = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic stray;
        do_reset();
        send1(4'd2, 4'd2); send1(4'd3, 4'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        send1(4'd4, 4'd4);
        reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        checks++; if (res_valid1 !== 1'b0) begin errors++; $display("FAIL mid_res_valid: got %0b expected 0", res_valid1); end
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %0b expected 1", in_ready1); end
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (res_valid1) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL mid_late_c: res_valid rose, expected stay 0"); end
        @(posedge clk); #1;
        send1(4'd5, 4'd1); send1(4'd6, 4'd1); send1(4'd7, 4'd1); send1(4'd8, 4'd1);
        repeat (3) @(negedge clk);
        checks++; if (acc1 !== 4) begin errors++; $display("FAIL mid_accepts: got %0d expected 4", acc1); end
        checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL mid_credits_used: got in_ready=%0b expected 0", in_ready1); end
        @(posedge clk); #1 res_ready = 1'b1;
        for (int k = 0; k < 40 && got1_d.size() < 4; k++) @(negedge clk);
        checks++; if (got1_d.size() != 4) begin errors++; $display("FAIL mid_count: got %0d expected 4", got1_d.size()); end
        for (int i = 0; i < got1_d.size() && i < 4; i++) begin
            checks++;
            if (got1_d[i] !== 7'(6 + i)) begin errors++; $display("FAIL mid_result[%0d]: got %0d expected %0d", i, got1_d[i], 6 + i); end
        end
        @(posedge clk); #1 res_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; res_ready = 1'b0; in_a = 4'd0; in_b = 4'd0;
        test_reset();
        test_single_op();
        test_backpressure();
        test_full_pushpop();
        test_streaming();
        test_mismatch();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
